// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state encoding, lamp codes and default durations for the traffic light controller.
package tlc_pkg;
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6
  } state_t;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;
  localparam int GREEN_T_DEF  = 20;
  localparam int YELLOW_T_DEF = 3;
  localparam int ALLRED_T_DEF = 2;
  localparam int WALK_T_DEF   = 10;
endpackage

// File: rtl/tlc_timer.sv
// tlc_timer: tick-enabled 8-bit phase counter; o_done fires on the tick that completes i_dur ticks.
module tlc_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_clr,
  input  logic [7:0] i_dur,
  output logic [7:0] o_count,
  output logic       o_done
);
  logic [7:0] r_count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_tick) r_count <= r_count + 8'd1;
  assign o_count = r_count;
  assign o_done  = i_tick && (r_count == i_dur - 8'd1);
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-way intersection sequencer with pedestrian walk phases.
// Night flashing mode is built only when TLC_NIGHT_FLASH_EN is defined.
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int GREEN_T  = GREEN_T_DEF,
  parameter int YELLOW_T = YELLOW_T_DEF,
  parameter int ALLRED_T = ALLRED_T_DEF,
  parameter int WALK_T   = WALK_T_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  input  logic       night,
  output logic [2:0] lamp_ns,
  output logic [2:0] lamp_ew,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] phase
);
  state_t     r_state, w_next;
  logic [7:0] w_count, w_dur;
  logic       w_done, w_night, w_chg, w_enter_ns, w_enter_ew;
  logic       r_pend_ns, r_pend_ew, r_walk_en_ns, r_walk_en_ew, r_flash;
  logic [2:0] w_lamp_ns, w_lamp_ew, r_lamp_ns, r_lamp_ew, r_phase;
  logic       w_walk_ns, w_walk_ew, r_walk_ns, r_walk_ew;
`ifdef TLC_NIGHT_FLASH_EN
  assign w_night = night;
`else
  assign w_night = night & 1'b0;
`endif
  always_comb
    w_dur = (r_state == NS_GREEN  || r_state == EW_GREEN)  ? 8'(GREEN_T)  :
            (r_state == NS_YELLOW || r_state == EW_YELLOW) ? 8'(YELLOW_T) :
            8'(ALLRED_T);
  tlc_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (tick),
    .i_clr   (w_chg),
    .i_dur   (w_dur),
    .o_count (w_count),
    .o_done  (w_done)
  );
  // Night cuts a green short but always runs yellow and all-red before flashing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      NS_GREEN:  w_next = (w_done || (w_night && tick)) ? NS_YELLOW : r_state;
      NS_YELLOW: w_next = w_done ? ALLRED_A : r_state;
      ALLRED_A:  w_next = w_done ? (w_night ? FLASH : EW_GREEN) : r_state;
      EW_GREEN:  w_next = (w_done || (w_night && tick)) ? EW_YELLOW : r_state;
      EW_YELLOW: w_next = w_done ? ALLRED_B : r_state;
      ALLRED_B:  w_next = w_done ? (w_night ? FLASH : NS_GREEN) : r_state;
      FLASH:     w_next = w_night ? FLASH : ALLRED_B;
      default:   w_next = ALLRED_B;
    endcase
  end
  assign w_chg      = (w_next != r_state);
  assign w_enter_ns = w_chg && (w_next == NS_GREEN);
  assign w_enter_ew = w_chg && (w_next == EW_GREEN);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state      <= ALLRED_B;
      r_pend_ns    <= 1'b0;
      r_pend_ew    <= 1'b0;
      r_walk_en_ns <= 1'b0;
      r_walk_en_ew <= 1'b0;
      r_flash      <= 1'b1;
    end else begin
      r_state      <= w_next;
      r_pend_ns    <= (r_state == FLASH || w_enter_ns) ? 1'b0 : (r_pend_ns | ped_req_ns);
      r_pend_ew    <= (r_state == FLASH || w_enter_ew) ? 1'b0 : (r_pend_ew | ped_req_ew);
      r_walk_en_ns <= w_enter_ns ? (r_pend_ns | ped_req_ns) : r_walk_en_ns;
      r_walk_en_ew <= w_enter_ew ? (r_pend_ew | ped_req_ew) : r_walk_en_ew;
      r_flash      <= (r_state != FLASH) ? 1'b1 : (r_flash ^ tick);
    end
  always_comb begin
    w_lamp_ns = RED;
    w_lamp_ew = RED;
    case (r_state)
      NS_GREEN:  w_lamp_ns = GREEN;
      NS_YELLOW: w_lamp_ns = YELLOW;
      EW_GREEN:  w_lamp_ew = GREEN;
      EW_YELLOW: w_lamp_ew = YELLOW;
      FLASH: begin
        w_lamp_ns = r_flash ? YELLOW : DARK;
        w_lamp_ew = r_flash ? YELLOW : DARK;
      end
      default: ;
    endcase
  end
  assign w_walk_ns = (r_state == NS_GREEN) && r_walk_en_ns && (w_count < 8'(WALK_T));
  assign w_walk_ew = (r_state == EW_GREEN) && r_walk_en_ew && (w_count < 8'(WALK_T));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_lamp_ns <= RED;
      r_lamp_ew <= RED;
      r_walk_ns <= 1'b0;
      r_walk_ew <= 1'b0;
      r_phase   <= ALLRED_B;
    end else begin
      r_lamp_ns <= w_lamp_ns;
      r_lamp_ew <= w_lamp_ew;
      r_walk_ns <= w_walk_ns;
      r_walk_ew <= w_walk_ew;
      r_phase   <= r_state;
    end
  assign lamp_ns = r_lamp_ns;
  assign lamp_ew = r_lamp_ew;
  assign walk_ns = r_walk_ns;
  assign walk_ew = r_walk_ew;
  assign phase   = r_phase;
endmodule
